// File: rtl/expr_chain_sequencer.sv
// Iterates acc = acc*K + d for N_STEPS cycles per accepted operand and
// presents the truncated 19-bit result with a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready high unless abort
// STEP  | one multiply-accumulate step per cycle
// DONE  | result presented until the consumer takes it or abort
module expr_chain_sequencer #(
    parameter logic [4:0]  K       = 5'd13,
    parameter int unsigned N_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] out_data,
    output logic        out_ovf,
    output logic        busy,
    output logic [7:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'(N_STEPS - 1);

    state_t      state_q, state_d;
    logic [18:0] acc_q, acc_d;
    logic [3:0]  d_q, d_d;
    logic [3:0]  step_q, step_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  ops_q, ops_d;
    logic [23:0] full;
    logic        accept;

    // Widest product is (2^19-1)*31 + 15, which always fits in 24 bits.
    assign full = ({5'd0, acc_q} * {19'd0, K}) + {20'd0, d_q};

    assign in_ready  = (state_q == IDLE) & ~abort;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        d_d     = d_q;
        step_d  = step_q;
        ovf_d   = ovf_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    d_d     = in_data;
                    acc_d   = {15'd0, in_data};
                    step_d  = 4'd0;
                    ovf_d   = 1'b0;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d  = full[18:0];
                    ovf_d  = ovf_q | (full[23:19] != 5'd0);
                    step_d = step_q + 4'd1;
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Abort wins over a simultaneous handshake.
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                    ops_d   = ops_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 19'd0;
            d_q     <= 4'd0;
            step_q  <= 4'd0;
            ovf_q   <= 1'b0;
            ops_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
            ops_q   <= ops_d;
        end
    end

endmodule

// File: tb/tb_expr_chain_sequencer.sv
// Scoreboard bench: a transaction model pushes expected results on accept,
// a negedge monitor compares and pops on each output handshake.
module tb_expr_chain_sequencer;

    localparam int N  = 4;
    localparam int KV = 13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [18:0] out_data;
    logic        out_ovf;
    logic        busy;
    logic [7:0]  ops_done;

    logic        in_valid5 = 1'b0;
    logic [3:0]  in_data5 = 4'd0;
    logic        in_ready5;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;
    logic [18:0] out_data5;
    logic        out_ovf5;
    logic        busy5;
    logic [7:0]  ops_done5;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int res;
        bit ovf;
    } exp_t;

    exp_t sb[$];

    int m_phase = 0;
    int m_rem = 0;
    int m_ops = 0;

    always #5 clk = ~clk;

    expr_chain_sequencer #(.K(5'd13), .N_STEPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .busy(busy), .ops_done(ops_done)
    );

    expr_chain_sequencer #(.K(5'd13), .N_STEPS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_data(in_data5),
        .in_ready(in_ready5), .abort(1'b0), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_data(out_data5), .out_ovf(out_ovf5),
        .busy(busy5), .ops_done(ops_done5)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input int d, input int n, output int res, output bit ovf);
        longint acc;
        longint full;
        acc = d;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            full = acc * KV + d;
            if (full >= (64'd1 << 19)) ovf = 1'b1;
            acc = full % (64'd1 << 19);
        end
        res = int'(acc);
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 result offered.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_phase = 0;
            m_ops = 0;
            sb.delete();
        end else begin
            case (m_phase)
                0: if (in_valid && !abort) begin
                    ref_calc(int'(in_data), N, e.res, e.ovf);
                    sb.push_back(e);
                    m_rem = N;
                    m_phase = 1;
                end
                1: if (abort) begin
                    m_phase = 0;
                    if (sb.size() > 0) void'(sb.pop_back());
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                2: if (abort) begin
                    m_phase = 0;
                    if (sb.size() > 0) void'(sb.pop_back());
                end else if (out_ready) begin
                    m_phase = 0;
                    m_ops = (m_ops + 1) % 256;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_phase == 0 && !abort));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("ops_done", int'(ops_done), m_ops);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("out_data", int'(out_data), sb[0].res);
                chk("out_ovf", int'(out_ovf), int'(sb[0].ovf));
                if (out_ready && !abort && rst_n) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic start_op(input logic [3:0] d, input logic rdy);
        out_ready = rdy;
        in_valid = 1'b1;
        in_data = d;
        step();
        in_valid = 1'b0;
        in_data = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int start_ops;
        int n;

        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        step();

        start_op(4'd1, 1'b1);
        wait_valid("op_d1");
        chk("d1_result", int'(out_data), 30941);
        chk("d1_ovf", int'(out_ovf), 0);
        step();
        @(negedge clk);
        chk("d1_ops", int'(ops_done), 1);
        step();

        start_op(4'd15, 1'b1);
        wait_valid("op_d15");
        chk("d15_result", int'(out_data), 464115);
        chk("d15_ovf", int'(out_ovf), 0);
        step();

        start_op(4'($urandom_range(0, 15)), 1'b0);
        wait_valid("op_bp");
        step();
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_ops", int'(ops_done), 3);
        step();

        in_valid = 1'b1;
        in_data = 4'd7;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ops", int'(ops_done), 3);
        step();
        start_op(4'd1, 1'b1);
        wait_valid("op_after_abort");
        chk("post_abort_result", int'(out_data), 30941);
        step();

        start_op(4'd9, 1'b1);
        wait_valid("op5");
        step();
        start_op(4'd3, 1'b0);
        wait_valid("op_rst");
        chk("pre_rst_ops", int'(ops_done), 5);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_out_data", int'(out_data), 0);
        chk("rst2_out_ovf", int'(out_ovf), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_ops", int'(ops_done), 0);
        step();

        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();

        start_ops = m_ops;
        in_valid = 1'b1;
        for (int i = 0; i < 256 * (N + 2); i++) begin
            in_data = 4'($urandom_range(0, 15));
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_ops", int'(ops_done), start_ops);
        chk("wrap_idle", int'(busy), 0);
        step();

        chk("dut5_in_ready", int'(in_ready5), 1);
        in_valid5 = 1'b1;
        in_data5 = 4'd15;
        step();
        in_valid5 = 1'b0;
        in_data5 = 4'd0;
        n = 0;
        @(negedge clk);
        while (!out_valid5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dut5_valid", int'(out_valid5), 1);
        chk("dut5_result", int'(out_data5), 266342);
        chk("dut5_ovf", int'(out_ovf5), 1);
        step();
        out_ready5 = 1'b1;
        step();
        out_ready5 = 1'b0;
        @(negedge clk);
        chk("dut5_busy", int'(busy5), 0);
        chk("dut5_ops", int'(ops_done5), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
